dec_n_scan: RTL and testbench
=============================

DEC_N_SCAN -- requirements
Module: dec_n_scan

Interface
REQ-001 Parameter N, default 3: select width; output width is 2**N.
REQ-002 Parameter STEP_DIV, default 1: scan-mode advance period in enabled clock cycles, legal range 1..256.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port En  input  1: enable; low blanks outputs and freezes scan state.
REQ-006 Port mode  input  2: 00 DECODE, 01 THERMO, 10 SCAN, 11 HOLD.
REQ-007 Port a  input  N: select index in DECODE/THERMO; scan start index on load.
REQ-008 Port load  input  1: in SCAN, copy a into scan index.
REQ-009 Port d  output  2**N: registered decoded output.
REQ-010 Port idx  output  N: registered index currently driving d.
REQ-011 Port wrap  output  1: registered one-cycle pulse on scan wrap-around.

Function
REQ-012 All outputs SHALL be registered; latency from a/mode/En to d/idx is exactly 1 cycle.
REQ-013 DECODE: d SHALL equal one-hot with only bit a set; idx = a.
REQ-014 THERMO: d[i] SHALL be 1 for all i <= a, else 0; idx = a; a = 2**N-1 gives all ones.
REQ-015 SCAN: d SHALL be one-hot of internal scan index; idx = scan index.
REQ-016 SCAN: a prescaler SHALL count enabled cycles 0..STEP_DIV-1; on terminal count the scan index increments by 1 and prescaler returns to 0.
REQ-017 SCAN wrap: index 2**N-1 SHALL advance to 0, and wrap SHALL be 1 for exactly the cycle in which idx first shows 0.
REQ-018 load in SCAN SHALL set scan index = a and clear prescaler; load beats a coincident step; load never asserts wrap.
REQ-019 load outside SCAN SHALL be ignored.
REQ-020 HOLD: d, idx, scan index and prescaler SHALL keep their values; wrap = 0.
REQ-021 En low (any mode): d SHALL be all zeros next cycle; idx, scan index, prescaler hold; wrap = 0; load ignored.
REQ-022 En rising SHALL resume SCAN from the held index and prescaler, with no skipped or repeated step.
REQ-023 Entering SCAN from another mode SHALL start from the current scan index (not a) unless load is asserted.
REQ-024 Mode change SHALL take effect on d the next cycle; scan index is unaffected by DECODE/THERMO.
REQ-025 At most one bit of d is set in DECODE/SCAN; wrap is never high outside SCAN.

Reset
REQ-026 rst high SHALL immediately force d = 0, idx = 0, wrap = 0, scan index = 0, prescaler = 0, independent of clk.
REQ-027 rst deasserted: first edge with En high SHALL produce normal operation; a scan in progress at reset restarts from index 0.

Structure
REQ-028 Shared package dec_pkg SHALL hold mode constants (MODE_DECODE, MODE_THERMO, MODE_SCAN, MODE_HOLD) and the output-width function 2**N.
REQ-029 One sub-module dec_onehot (parametrised N, combinational index -> one-hot) SHALL be instanced for DECODE/SCAN; thermometer derived in-line.
REQ-030 Prescaler width SHALL be derived from STEP_DIV; STEP_DIV = 1 degenerates to advance every enabled cycle.

Verification
REQ-031 N=3, DECODE, En=1, a=5 -> d=8'b0010_0000, idx=5 one cycle later.
REQ-032 N=3, THERMO, a=3 -> d=8'b0000_1111; a=7 -> d=8'hFF.
REQ-033 N=3, STEP_DIV=2, SCAN, load a=6 -> idx 6,6,7,7,0,0; wrap high only on first idx=0 cycle.
REQ-034 SCAN running at idx=2, En low 3 cycles -> d=0, idx=2 held; En high -> advance continues from 2 with no skipped or repeated step.
REQ-035 load with a=1 coincident with terminal-count step from idx=4 -> idx=1, wrap=0.
REQ-036 rst asserted mid-scan between edges -> d=0, idx=0, wrap=0 immediately; post-release SCAN restarts at 0.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared definitions for the decoder/scanner: mode encoding and output width.
package dec_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE = 2'b00,
    MODE_THERMO = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  function automatic int out_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational index to one-hot converter, shared by DECODE and SCAN paths.
module dec_onehot
  import dec_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]        idx_i,
  output logic [out_w(N)-1:0] onehot_o
);

  always_comb begin
    // NOTE: assign a default before the conditional write so no latch is inferred.
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/dec_n_scan.sv
// N-to-2**N decoder with thermometer and prescaled scanning modes; all outputs registered.
module dec_n_scan
  import dec_pkg::*;
#(
  parameter int N        = 3,
  parameter int STEP_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                En,
  input  logic [1:0]          mode,
  input  logic [N-1:0]        a,
  input  logic                load,
  output logic [out_w(N)-1:0] d,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int            W  = out_w(N);
  localparam int            PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(STEP_DIV - 1);

  mode_e         mode_s;
  logic          scan_en;
  logic [N-1:0]  scan_q, scan_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  d_q, d_d;
  logic [N-1:0]  idx_q, idx_d;
  logic          wrap_q, wrap_d;
  logic [N-1:0]  sel;
  logic [W-1:0]  onehot;
  logic [W-1:0]  thermo;

  assign mode_s  = mode_e'(mode);
  assign scan_en = En && (mode_s == MODE_SCAN);

  // Scan state only moves on enabled SCAN cycles; load wins over a coincident step.
  always_comb begin
    scan_d  = scan_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (scan_en) begin
      if (load) begin
        scan_d  = a;
        presc_d = '0;
      end else if (presc_q == TC) begin
        presc_d = '0;
        scan_d  = scan_q + 1'b1;
        wrap_d  = &scan_q;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // SCAN shows the index it is moving to, so d and idx track the scan register with one cycle latency.
  assign sel = (mode_s == MODE_SCAN) ? scan_d : a;

  dec_onehot #(.N(N)) u_onehot (
    .idx_i    (sel),
    .onehot_o (onehot)
  );

  always_comb begin
    for (int i = 0; i < W; i++) begin
      thermo[i] = (i <= int'(a));
    end
  end

  always_comb begin
    d_d   = d_q;
    idx_d = idx_q;
    if (!En) begin
      d_d = '0;
    end else begin
      case (mode_s)
        MODE_DECODE: begin d_d = onehot; idx_d = a;      end
        MODE_THERMO: begin d_d = thermo; idx_d = a;      end
        MODE_SCAN:   begin d_d = onehot; idx_d = scan_d; end
        MODE_HOLD:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q  <= '0;
      presc_q <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      scan_q  <= scan_d;
      presc_q <= presc_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
    end
  end

  assign d    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_n_scan.sv
// Directed self-checking bench for dec_n_scan with N=3, STEP_DIV=2.
module tb_dec_n_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       En;
  logic [1:0] mode;
  logic [2:0] a;
  logic       load;
  logic [7:0] d;
  logic [2:0] idx;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] M_DEC = 2'b00, M_THR = 2'b01, M_SCN = 2'b10, M_HLD = 2'b11;

  dec_n_scan #(.N(3), .STEP_DIV(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .En   (En),
    .mode (mode),
    .a    (a),
    .load (load),
    .d    (d),
    .idx  (idx),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] d_e, input logic [2:0] idx_e, input logic wrap_e);
    check({tag, ".d"}, 32'(d), 32'(d_e));
    check({tag, ".idx"}, 32'(idx), 32'(idx_e));
    check({tag, ".wrap"}, 32'(wrap), 32'(wrap_e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; En = 1'b0; mode = M_DEC; a = 3'd0; load = 1'b0;
    #3;
    chk("reset", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    En = 1'b1; mode = M_DEC; a = 3'd5;
    tick(); chk("dec_a5", 8'h20, 3'd5, 1'b0);
    a = 3'd0;
    tick(); chk("dec_a0", 8'h01, 3'd0, 1'b0);
    mode = M_THR; a = 3'd3;
    tick(); chk("thr_a3", 8'h0F, 3'd3, 1'b0);
    a = 3'd7;
    tick(); chk("thr_a7", 8'hFF, 3'd7, 1'b0);
    a = 3'd0;
    tick(); chk("thr_a0", 8'h01, 3'd0, 1'b0);
    En = 1'b0;
    tick(); chk("en_low_thr", 8'h00, 3'd0, 1'b0);

    En = 1'b1; mode = M_DEC; a = 3'd2; load = 1'b1;
    tick(); chk("dec_load_ignored", 8'h04, 3'd2, 1'b0);

    load = 1'b0; mode = M_SCN; a = 3'd5;
    tick(); chk("scan_entry0", 8'h01, 3'd0, 1'b0);
    tick(); chk("scan_entry1", 8'h02, 3'd1, 1'b0);

    load = 1'b1; a = 3'd6;
    tick(); chk("load6", 8'h40, 3'd6, 1'b0);
    load = 1'b0;
    tick(); chk("seq6b", 8'h40, 3'd6, 1'b0);
    tick(); chk("seq7a", 8'h80, 3'd7, 1'b0);
    tick(); chk("seq7b", 8'h80, 3'd7, 1'b0);
    tick(); chk("seq0a_wrap", 8'h01, 3'd0, 1'b1);
    tick(); chk("seq0b", 8'h01, 3'd0, 1'b0);
    tick(); chk("seq1a", 8'h02, 3'd1, 1'b0);
    tick(); chk("seq1b", 8'h02, 3'd1, 1'b0);
    tick(); chk("seq2a", 8'h04, 3'd2, 1'b0);

    En = 1'b0; load = 1'b1; a = 3'd7;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("en_low_scan", 8'h00, 3'd2, 1'b0);
    end
    En = 1'b1; load = 1'b0;
    tick(); chk("resume2b", 8'h04, 3'd2, 1'b0);
    tick(); chk("resume3a", 8'h08, 3'd3, 1'b0);
    tick(); chk("resume3b", 8'h08, 3'd3, 1'b0);
    tick(); chk("resume4a", 8'h10, 3'd4, 1'b0);
    tick(); chk("resume4b", 8'h10, 3'd4, 1'b0);

    load = 1'b1; a = 3'd1;
    tick(); chk("load_beats_step", 8'h02, 3'd1, 1'b0);
    a = 3'd7;
    tick(); chk("load7", 8'h80, 3'd7, 1'b0);
    load = 1'b0;
    tick(); chk("at7_term", 8'h80, 3'd7, 1'b0);
    load = 1'b1; a = 3'd3;
    tick(); chk("load_beats_wrap", 8'h08, 3'd3, 1'b0);

    load = 1'b0; mode = M_HLD; a = 3'd6;
    tick(); chk("hold1", 8'h08, 3'd3, 1'b0);
    tick(); chk("hold2", 8'h08, 3'd3, 1'b0);
    mode = M_SCN;
    tick(); chk("after_hold3b", 8'h08, 3'd3, 1'b0);
    tick(); chk("after_hold4a", 8'h10, 3'd4, 1'b0);
    tick(); chk("after_hold4b", 8'h10, 3'd4, 1'b0);

    #2; rst = 1'b1;
    #1; chk("async_rst", 8'h00, 3'd0, 1'b0);
    #2; rst = 1'b0;
    tick(); chk("post_rst0", 8'h01, 3'd0, 1'b0);
    tick(); chk("post_rst1", 8'h02, 3'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
